// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types and fixed bus widths.
package wb_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned SELW = 4;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping to 0.
module wb_rr_pick #(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned MW      = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req_i,
  input  logic [MW-1:0]      ptr_i,
  output logic [MASTERS-1:0] win_o,
  output logic [MW-1:0]      idx_o
);

  logic [MASTERS-1:0] at_or_above;
  logic [MASTERS-1:0] cand;

  // Prefer requesters at or above the pointer; otherwise wrap and take the lowest.
  always_comb begin
    at_or_above = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      at_or_above[i] = (32'(ptr_i) <= i);
    end
    cand  = (|(req_i & at_or_above)) ? (req_i & at_or_above) : req_i;
    // Isolate the lowest set bit of the candidate vector.
    win_o = cand & ~(cand - MASTERS'(1));
  end

  // Encode the one-hot winner; scanning downward leaves the lowest index.
  always_comb begin
    idx_o = '0;
    for (int i = int'(MASTERS) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx_o = MW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: grant held for a whole cyc, bus mux and ack/err demux.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned TO_CYC  = 255,
  parameter int unsigned MW      = $clog2(MASTERS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [MASTERS-1:0]      m_cyc_i,
  input  logic [MASTERS-1:0]      m_stb_i,
  input  logic [MASTERS-1:0]      m_we_i,
  input  logic [MASTERS*SELW-1:0] m_sel_i,
  input  logic [MASTERS*AW-1:0]   m_adr_i,
  input  logic [MASTERS*DW-1:0]   m_dat_i,
  output logic [MASTERS-1:0]      m_ack_o,
  output logic [MASTERS-1:0]      m_err_o,
  output logic [DW-1:0]           m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [SELW-1:0]         s_sel_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  input  logic                    s_ack_i,
  input  logic [DW-1:0]           s_dat_i,
  output logic [MW-1:0]           gnt_o
);

  if (MASTERS < 2) begin : g_bad_masters
    $error("wb_arbiter: MASTERS must be >= 2");
  end
  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("wb_arbiter: TO_CYC must be >= 1");
  end

  arb_state_t         state_q, state_d;
  logic [MW-1:0]      gnt_q, gnt_d;
  logic [MW-1:0]      ptr_q, ptr_d;
  logic [MASTERS-1:0] pick_win;
  logic [MW-1:0]      pick_idx;
  logic               busy;
  logic               gnt_cyc;
  int unsigned        gnt_idx;

  assign busy    = (state_q == ARB_BUSY);
  assign gnt_cyc = m_cyc_i[gnt_q];
  assign gnt_idx = 32'(gnt_q);
  assign gnt_o   = gnt_q;

  wb_rr_pick #(
    .MASTERS (MASTERS),
    .MW      (MW)
  ) u_pick (
    .req_i (m_cyc_i),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned ToBits = $clog2(TO_CYC + 1);
  localparam int unsigned ToW    = (ToBits < 8) ? 8 : ((ToBits > 16) ? 16 : ToBits);

  logic [ToW-1:0] cnt_q, cnt_d;
  logic           to_err;

  // Count unacknowledged strobe cycles; the expiring cycle raises err unless ack lands.
  always_comb begin
    cnt_d  = '0;
    to_err = 1'b0;
    if (busy && s_stb_o && !s_ack_i) begin
      if (cnt_q == ToW'(TO_CYC - 1)) begin
        to_err = 1'b1;
      end else begin
        cnt_d = cnt_q + ToW'(1);
      end
    end
  end
`endif

  // Grant FSM next state: arbitrate in IDLE, hold until the granted master drops cyc.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|pick_win) begin
          gnt_d   = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!gnt_cyc) begin
          ptr_d   = (gnt_q == MW'(MASTERS - 1)) ? '0 : gnt_q + MW'(1);
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, grant and pointer registers; reset drops any cycle in flight at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Bus mux from the granted master and ack/err/data return to it alone.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    if (busy) begin
      s_cyc_o          = gnt_cyc;
      s_stb_o          = gnt_cyc & m_stb_i[gnt_q];
      s_we_o           = m_we_i[gnt_q];
      s_sel_o          = m_sel_i[gnt_idx*SELW +: SELW];
      s_adr_o          = m_adr_i[gnt_idx*AW +: AW];
      s_dat_o          = m_dat_i[gnt_idx*DW +: DW];
      m_ack_o[gnt_q]   = s_ack_i;
      m_dat_o          = s_dat_i;
`ifdef WB_ARB_TIMEOUT_EN
      m_err_o[gnt_q]   = to_err;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (4 masters, TO_CYC=8).
module tb_wb_arbiter;

  localparam int unsigned M  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned MW = 2;

  logic            clk_i;
  logic            rst_ni;
  logic [M-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [M*SW-1:0] m_sel_i;
  logic [M*AW-1:0] m_adr_i;
  logic [M*DW-1:0] m_dat_i;
  logic [M-1:0]    m_ack_o, m_err_o;
  logic [DW-1:0]   m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]   s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_ack_i;
  logic [DW-1:0]   s_dat_i;
  logic [MW-1:0]   gnt_o;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(
    .MASTERS (M),
    .AW      (AW),
    .TO_CYC  (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_sel_i (m_sel_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_dat_o (m_dat_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_ack_i (s_ack_i),
    .s_dat_i (s_dat_i),
    .gnt_o   (gnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 2 time units after a rising edge; outputs are read 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_m(input int k, input logic cyc, input logic stb, input logic [31:0] adr);
    m_cyc_i[k]           = cyc;
    m_stb_i[k]           = stb;
    m_we_i[k]            = adr[4];
    m_sel_i[k*SW +: SW]  = 4'hF;
    m_adr_i[k*AW +: AW]  = adr;
    m_dat_i[k*DW +: DW]  = ~adr;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    drive_m(0, 1'b1, 1'b1, 32'h55);
    s_ack_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    step();
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, gnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got cyc=%b stb=%b ack=%b err=%b gnt=%0d, expected all 0",
               s_cyc_o, s_stb_o, m_ack_o, m_err_o, gnt_o);
    end
    checks++;
    if ({s_adr_o, s_dat_o, s_sel_o, m_dat_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: got adr=%h dat=%h sel=%h mdat=%h, expected all 0",
               s_adr_o, s_dat_o, s_sel_o, m_dat_o);
    end
    clear_inputs();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    drive_m(1, 1'b1, 1'b1, 32'h100);
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      failures++; $display("FAIL single_idle_cyc: got %b expected 0", s_cyc_o);
    end
    step(); #1;
    checks++;
    if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin
      failures++; $display("FAIL single_grant: got cyc=%b stb=%b expected 1 1", s_cyc_o, s_stb_o);
    end
    checks++;
    if (gnt_o !== 2'd1 || s_adr_o !== 32'h100) begin
      failures++; $display("FAIL single_mux: got gnt=%0d adr=%h expected 1 100", gnt_o, s_adr_o);
    end
    checks++;
    if (m_ack_o !== 4'b0000) begin
      failures++; $display("FAIL single_noack: got %b expected 0000", m_ack_o);
    end
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_F00D;
    #1;
    checks++;
    if (m_ack_o !== 4'b0010) begin
      failures++; $display("FAIL single_ack: got %b expected 0010", m_ack_o);
    end
    checks++;
    if (m_dat_o !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL single_rdata: got %h expected cafef00d", m_dat_o);
    end
    step();
    drive_m(1, 1'b0, 1'b0, 32'h100);
    s_ack_i = 1'b0;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0 || m_ack_o !== 4'b0000) begin
      failures++; $display("FAIL single_release: got cyc=%b ack=%b expected 0 0000", s_cyc_o, m_ack_o);
    end
    step();
    // Strobe without cyc must not start a grant.
    drive_m(3, 1'b0, 1'b1, 32'h300);
    step(); #1;
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      failures++; $display("FAIL stb_no_cyc: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 4; k++) drive_m(k, 1'b1, 1'b1, 32'h1000 + 32'(k) * 16);
    step();
    for (int i = 0; i < 5; i++) begin
      int g;
      g = exp_seq[i];
      #1;
      checks++;
      if (gnt_o !== MW'(g) || s_cyc_o !== 1'b1 || s_adr_o !== 32'h1000 + 32'(g) * 16) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got gnt=%0d cyc=%b adr=%h expected %0d 1 %h",
                 i, gnt_o, s_cyc_o, s_adr_o, g, 32'h1000 + 32'(g) * 16);
      end
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (m_ack_o !== 4'(1 << g)) begin
        failures++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, m_ack_o, 4'(1 << g));
      end
      step();
      drive_m(g, 1'b0, 1'b0, 32'h1000 + 32'(g) * 16);
      s_ack_i = 1'b0;
      step(); #1;
      checks++;
      if (s_cyc_o !== 1'b0) begin
        failures++; $display("FAIL rr_idle_gap[%0d]: got cyc=%b expected 0", i, s_cyc_o);
      end
      drive_m(g, 1'b1, 1'b1, 32'h1000 + 32'(g) * 16);
      step();
    end
    clear_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 32'hA0);
    drive_m(2, 1'b1, 1'b1, 32'hC0);
    step();
    for (int p = 0; p < 3; p++) begin
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (gnt_o !== 2'd0 || m_ack_o !== 4'b0001) begin
        failures++; $display("FAIL hold_phase[%0d]: got gnt=%0d ack=%b expected 0 0001", p, gnt_o, m_ack_o);
      end
      step();
      m_stb_i[0] = 1'b0;
      s_ack_i    = 1'b0;
      #1;
      checks++;
      if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b0 || m_ack_o !== 4'b0000) begin
        failures++;
        $display("FAIL hold_gap[%0d]: got cyc=%b stb=%b ack=%b expected 1 0 0000",
                 p, s_cyc_o, s_stb_o, m_ack_o);
      end
      step();
      if (p < 2) m_stb_i[0] = 1'b1;
      else       m_cyc_i[0] = 1'b0;
    end
    #1;
    checks++;
    if (s_cyc_o !== 1'b0 || gnt_o !== 2'd0) begin
      failures++; $display("FAIL hold_release: got cyc=%b gnt=%0d expected 0 0", s_cyc_o, gnt_o);
    end
    step(); #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      failures++; $display("FAIL hold_idle: got cyc=%b expected 0", s_cyc_o);
    end
    step(); #1;
    checks++;
    if (gnt_o !== 2'd2 || s_cyc_o !== 1'b1 || s_adr_o !== 32'hC0) begin
      failures++; $display("FAIL hold_next: got gnt=%0d cyc=%b adr=%h expected 2 1 c0", gnt_o, s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 4'b0100) begin
      failures++; $display("FAIL hold_next_ack: got %b expected 0100", m_ack_o);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 32'h10);
    step();
    s_ack_i = 1'b1;
    step();
    drive_m(0, 1'b0, 1'b0, 32'h10);
    s_ack_i = 1'b0;
    step();
    // ptr is now 1, so master 2 wins over master 0.
    drive_m(0, 1'b1, 1'b1, 32'h10);
    drive_m(2, 1'b1, 1'b1, 32'h20);
    step(); #1;
    checks++;
    if (gnt_o !== 2'd2) begin
      failures++; $display("FAIL midrst_pre_gnt: got %0d expected 2", gnt_o);
    end
    s_ack_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== 4'b0000 || gnt_o !== 2'd0) begin
      failures++;
      $display("FAIL midrst_async: got cyc=%b stb=%b ack=%b gnt=%0d expected 0 0 0000 0",
               s_cyc_o, s_stb_o, m_ack_o, gnt_o);
    end
    step();
    s_ack_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step(); #1;
    checks++;
    if (gnt_o !== 2'd0 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h10) begin
      failures++;
      $display("FAIL midrst_ptr0: got gnt=%0d cyc=%b adr=%h expected 0 1 10", gnt_o, s_cyc_o, s_adr_o);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] exp_err;
    do_reset();
    drive_m(1, 1'b1, 1'b1, 32'h40);
    step();
    for (int c = 1; c <= 9; c++) begin
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (c == 8) ? 4'b0010 : 4'b0000;
`else
      exp_err = 4'b0000;
`endif
      #1;
      checks++;
      if (m_err_o !== exp_err || m_ack_o !== 4'b0000) begin
        failures++;
        $display("FAIL timeout_cycle[%0d]: got err=%b ack=%b expected %b 0000", c, m_err_o, m_ack_o, exp_err);
      end
      step();
    end
    // Ack landing on the expiry cycle wins over err.
    do_reset();
    drive_m(1, 1'b1, 1'b1, 32'h40);
    step();
    for (int c = 1; c < 8; c++) step();
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 4'b0010 || m_err_o !== 4'b0000) begin
      failures++; $display("FAIL timeout_ack_wins: got ack=%b err=%b expected 0010 0000", m_ack_o, m_err_o);
    end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
